mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage pipeline CPU. Sits directly downstream of the EX/MEM register. It takes the registered ALU result, store data, destination and control bits, and runs the load/store against a variable-latency data-memory port using a req/ready handshake. While an access is outstanding it stalls the upstream stages. It then registers the write-back value, destination and RegWrite for the WB stage.

## Interface
- DATA_W, 32, datapath/address width
- TIMEOUT_CYC, 16, max cycles to wait for dmem_ready before aborting the access (≥2)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_MemtoReg  in  1  WB selects memory read data (1) or ALU result (0)
- i_MemRead  in  1  load in EX/MEM
- i_MemWrite  in  1  store in EX/MEM
- i_RegWrite  in  1  instruction writes register file
- i_alu_out  in  DATA_W  byte address / ALU result
- i_alu_b  in  DATA_W  store data
- i_dest  in  5  destination register (already rd/rt-resolved)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DATA_W  equals i_alu_out
- dmem_wdata  out  DATA_W  equals i_alu_b
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready=1
- dmem_ready  in  1  access completes this cycle
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- o_RegWrite  out  1  MEM/WB: write enable
- o_dest  out  5  MEM/WB: destination register
- o_wb_data  out  DATA_W  MEM/WB: write-back value
- o_misalign  out  1  MEM/WB: faulted instruction was misaligned (1-cycle pulse)
- o_bus_err  out  1  sticky: an access timed out; cleared only by reset

## Operation
- mem_op = (i_MemRead | i_MemWrite) & aligned, where aligned = (i_alu_out[1:0]==0). If both MemRead and MemWrite are set, the access is a write.
- FSM states are IDLE and WAIT. Cycle counter wcnt is $clog2(TIMEOUT_CYC+1) bits.
- IDLE:
  - mem_op=1 → dmem_req=1 combinationally.
  - If dmem_ready=1 the access completes (zero-wait) and the state stays IDLE. Otherwise go to WAIT with wcnt=1.
- WAIT:
  - dmem_req held at 1. addr, we and wdata stay stable because EX/MEM is frozen by stall.
  - dmem_ready=1 → complete, go to IDLE, wcnt=0.
  - Otherwise, wcnt==TIMEOUT_CYC → abort: drop req next cycle, go to IDLE, set o_bus_err, load a bubble.
  - Otherwise wcnt++.
- stall = mem_op & ~dmem_ready & ~abort. It is combinational and is never asserted for non-memory instructions.
- Misaligned load/store:
  - No request is issued and no stall occurs.
  - MEM/WB loads a bubble (RegWrite=0, dest=0, data=0) with o_misalign=1.
- MEM/WB register loads on every rising clk:
  - stall=1 → bubble (o_RegWrite=0, o_dest=0, o_wb_data=0, o_misalign=0).
  - Otherwise → o_RegWrite=i_RegWrite, o_dest=i_dest, o_wb_data = i_MemtoReg ? dmem_rdata : i_alu_out.
- Reset values: state=IDLE, wcnt=0, every registered output 0, o_bus_err=0. Combinational outputs are 0 when no mem_op is present.

## Timing
- Non-memory instruction: 1 cycle; result appears at MEM/WB on the next edge.
- Load/store with N wait cycles (ready arrives N cycles after the first req cycle): stall high for N cycles, result registered on the edge of the ready cycle. Total 1+N cycles.
- ready and timeout in the same cycle: ready wins, normal completion.
- Store completes with ready=1; rdata is ignored unless MemtoReg=1.
- Reset asserted mid-WAIT: req and stall drop immediately (async); no partial write-back.
- Back-to-back loads: the second req is raised in the cycle after the first completes, with no idle gap.

## Structure
- Shared package pipe_pkg:
  - state enum {IDLE, WAIT}
  - DATA_W default
  - REG_ZERO = 5'd0
  - bubble constant for the MEM/WB bundle
- One sub-module, mem_wb_reg: a plain MEM/WB register with async reset and a bubble input.
- FSM, counter and handshake logic stay in mem_wb_stage.

## Test plan
- ALU op: i_RegWrite=1, i_dest=5, i_alu_out=0x1234, no mem → stall=0; next edge o_dest=5, o_wb_data=0x1234, o_RegWrite=1.
- Zero-wait load: addr 0x40, ready=1 same cycle, rdata=0xDEADBEEF, MemtoReg=1 → stall never high; o_wb_data=0xDEADBEEF.
- Load with 3 wait cycles: stall high exactly 3 cycles, MEM/WB shows bubbles meanwhile; data captured in the ready cycle.
- Store to 0x44 with 2 waits → dmem_we=1, dmem_wdata=i_alu_b stable throughout; o_RegWrite=0 after completion.
- Misaligned load at 0x42 → dmem_req never asserted; o_misalign=1 for one cycle, o_RegWrite=0.
- Timeout with ready held 0 → stall for TIMEOUT_CYC cycles then release; o_bus_err=1 and stays set; reset mid-WAIT clears all outputs immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline CPU.
// Holds the MEM stage FSM states and the MEM/WB bubble value.
package pipe_pkg;

  localparam int DATA_W_DFLT = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Control portion of the MEM/WB bundle. The data field is sized per instance.
  typedef struct packed {
    logic       reg_write;
    logic [4:0] dest;
    logic       misalign;
  } memwb_ctrl_t;

  localparam memwb_ctrl_t MEMWB_CTRL_BUBBLE = '{
    reg_write: 1'b0,
    dest:      REG_ZERO,
    misalign:  1'b0
  };

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the next bundle every cycle, or a bubble.
module mem_wb_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_bubble,
  input  memwb_ctrl_t       i_ctrl,
  input  logic [DATA_W-1:0] i_wb_data,
  output memwb_ctrl_t       o_ctrl,
  output logic [DATA_W-1:0] o_wb_data
);

  memwb_ctrl_t       r_ctrl;
  logic [DATA_W-1:0] r_wb_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= MEMWB_CTRL_BUBBLE;
      r_wb_data <= '0;
    end else if (i_bubble) begin
      r_ctrl    <= MEMWB_CTRL_BUBBLE;
      r_wb_data <= '0;
    end else begin
      r_ctrl    <= i_ctrl;
      r_wb_data <= i_wb_data;
    end
  end

  assign o_ctrl    = r_ctrl;
  assign o_wb_data = r_wb_data;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with variable-latency dmem handshake, timeout abort,
// misalignment fault and the MEM/WB pipeline register.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DFLT,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_MemtoReg,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic              i_RegWrite,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic [DATA_W-1:0] i_alu_b,
  input  logic [4:0]        i_dest,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall,
  output logic              o_RegWrite,
  output logic [4:0]        o_dest,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_misalign,
  output logic              o_bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_wcnt;
  logic              r_bus_err;

  logic              w_mem_any;
  logic              w_aligned;
  logic              w_mem_op;
  logic              w_misalign;
  logic              w_abort;
  logic              w_bubble;
  memwb_ctrl_t       w_next_ctrl;
  logic [DATA_W-1:0] w_next_data;
  memwb_ctrl_t       w_memwb_ctrl;

  assign w_mem_any = i_MemRead | i_MemWrite;
  assign w_aligned = is_word_aligned(i_alu_out[1:0]);

  // Qualifying with rst_n makes req and stall fall the instant reset asserts,
  // even while EX/MEM still presents the frozen access.
  assign w_mem_op   = rst_n & w_mem_any & w_aligned;
  assign w_misalign = rst_n & w_mem_any & ~w_aligned;

  // A same-cycle ready beats the timeout.
  assign w_abort = w_mem_op & (r_state == WAIT) & ~dmem_ready
                 & (r_wcnt == CNT_W'(TIMEOUT_CYC));

  assign stall      = w_mem_op & ~dmem_ready & ~w_abort;
  assign dmem_req   = w_mem_op;
  assign dmem_we    = w_mem_op & i_MemWrite;
  assign dmem_addr  = w_mem_op ? i_alu_out : '0;
  assign dmem_wdata = w_mem_op ? i_alu_b   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op && !dmem_ready) begin
            r_state <= WAIT;
            r_wcnt  <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (dmem_ready || !w_mem_op) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
          end else if (w_abort) begin
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_bus_err <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_wcnt  <= '0;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_ctrl           = MEMWB_CTRL_BUBBLE;
    w_next_data           = '0;
    if (w_misalign) begin
      w_next_ctrl.misalign = 1'b1;
    end else begin
      w_next_ctrl.reg_write = i_RegWrite;
      w_next_ctrl.dest      = i_dest;
      w_next_data           = i_MemtoReg ? dmem_rdata : i_alu_out;
    end
  end

  // Waiting cycles and an aborted access both leave a hole in the pipeline.
  assign w_bubble = stall | w_abort;

  mem_wb_reg #(
    .DATA_W (DATA_W)
  ) u_mem_wb_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_bubble  (w_bubble),
    .i_ctrl    (w_next_ctrl),
    .i_wb_data (w_next_data),
    .o_ctrl    (w_memwb_ctrl),
    .o_wb_data (o_wb_data)
  );

  assign o_RegWrite = w_memwb_ctrl.reg_write;
  assign o_dest     = w_memwb_ctrl.dest;
  assign o_misalign = w_memwb_ctrl.misalign;
  assign o_bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver issues instructions with a chosen
// memory latency and queues per-cycle expectations; a monitor compares them.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int TO = 6;

  logic          clk;
  logic          rst_n;
  logic          i_MemtoReg, i_MemRead, i_MemWrite, i_RegWrite;
  logic [DW-1:0] i_alu_out, i_alu_b;
  logic [4:0]    i_dest;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_ready;
  logic          stall;
  logic          o_RegWrite;
  logic [4:0]    o_dest;
  logic [DW-1:0] o_wb_data;
  logic          o_misalign, o_bus_err;

  mem_wb_stage #(
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_MemtoReg (i_MemtoReg),
    .i_MemRead  (i_MemRead),
    .i_MemWrite (i_MemWrite),
    .i_RegWrite (i_RegWrite),
    .i_alu_out  (i_alu_out),
    .i_alu_b    (i_alu_b),
    .i_dest     (i_dest),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .stall      (stall),
    .o_RegWrite (o_RegWrite),
    .o_dest     (o_dest),
    .o_wb_data  (o_wb_data),
    .o_misalign (o_misalign),
    .o_bus_err  (o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = cycles after the first request cycle at which ready arrives; -1 = never.
  typedef struct {
    bit          rd, wr, m2r, rw;
    logic [4:0]  dest;
    logic [31:0] alu, b, rdata;
    int          lat;
  } instr_t;

  typedef struct {
    logic        stall, req, we;
    logic [31:0] addr, wdata;
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        mis, berr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   drv_done = 0;
  bit   berr_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_MemtoReg = 0; i_MemRead = 0; i_MemWrite = 0; i_RegWrite = 0;
    i_alu_out = '0; i_alu_b = '0; i_dest = '0;
    dmem_rdata = '0; dmem_ready = 0;
  endtask

  // Reference behaviour: a memory op occupies cycles until ready, or until TO
  // wait cycles have passed; only the completing cycle carries the result.
  task automatic run_instr(input instr_t in);
    int   c = 0;
    bit   fin = 0;
    bit   is_mem, aligned, done_now, abort_now;
    exp_t e;
    is_mem  = in.rd | in.wr;
    aligned = (in.alu % 4) == 0;
    while (!fin) begin
      @(negedge clk);
      i_MemRead = in.rd; i_MemWrite = in.wr; i_MemtoReg = in.m2r; i_RegWrite = in.rw;
      i_alu_out = in.alu; i_alu_b = in.b; i_dest = in.dest;
      e = '{stall: 0, req: 0, we: 0, addr: 0, wdata: 0, rw: 0, dest: 0, data: 0,
            mis: 0, berr: 0};
      if (!is_mem) begin
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        e.rw = in.rw; e.dest = in.dest;
        e.data = in.m2r ? dmem_rdata : in.alu;
        fin = 1;
      end else if (!aligned) begin
        dmem_ready = 0;
        dmem_rdata = $urandom;
        e.mis = 1;
        fin = 1;
      end else begin
        done_now   = (c == in.lat);
        abort_now  = !done_now && (c == TO);
        dmem_ready = done_now;
        dmem_rdata = done_now ? in.rdata : $urandom;
        e.stall = !done_now && !abort_now;
        e.req = 1; e.we = in.wr; e.addr = in.alu; e.wdata = in.b;
        if (done_now) begin
          e.rw = in.rw; e.dest = in.dest;
          e.data = in.m2r ? in.rdata : in.alu;
        end
        if (abort_now) berr_model = 1;
        fin = done_now || abort_now;
      end
      e.berr = berr_model;
      sb.push_back(e);
      c++;
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t in;
    int     kind, r;
    kind     = $urandom_range(0, 3);
    in.dest  = 5'($urandom_range(1, 31));
    in.b     = $urandom;
    in.rdata = $urandom;
    in.alu   = $urandom;
    in.m2r   = 0; in.rd = 0; in.wr = 0; in.rw = 1;
    case (kind)
      0: in.m2r = 1'($urandom_range(0, 1));
      1: begin in.rd = 1; in.m2r = 1; in.alu[1:0] = 2'b00; end
      2: begin in.wr = 1; in.rd = 1'($urandom_range(0, 1)); in.rw = 0; in.alu[1:0] = 2'b00; end
      default: begin
        in.rd = 1; in.wr = 1'($urandom_range(0, 1));
        in.alu[1:0] = 2'($urandom_range(1, 3));
      end
    endcase
    r = $urandom_range(0, 9);
    if (r <= 5)      in.lat = r % 4;
    else if (r <= 7) in.lat = TO;
    else if (r == 8) in.lat = TO - 1;
    else             in.lat = -1;
    return in;
  endfunction

  task automatic run_driver();
    instr_t dir[$];
    dir.push_back('{rd:0, wr:0, m2r:0, rw:1, dest:5,  alu:32'h1234, b:0,            rdata:0,            lat:0});
    dir.push_back('{rd:1, wr:0, m2r:1, rw:1, dest:8,  alu:32'h40,   b:0,            rdata:32'hDEADBEEF, lat:0});
    dir.push_back('{rd:1, wr:0, m2r:1, rw:1, dest:9,  alu:32'h48,   b:0,            rdata:32'h0BADF00D, lat:3});
    dir.push_back('{rd:1, wr:0, m2r:1, rw:1, dest:10, alu:32'h4C,   b:0,            rdata:32'h11223344, lat:1});
    dir.push_back('{rd:0, wr:1, m2r:0, rw:0, dest:0,  alu:32'h44,   b:32'hCAFEF00D, rdata:32'h55555555, lat:2});
    dir.push_back('{rd:1, wr:0, m2r:1, rw:1, dest:7,  alu:32'h42,   b:0,            rdata:0,            lat:0});
    dir.push_back('{rd:1, wr:0, m2r:1, rw:1, dest:11, alu:32'h50,   b:0,            rdata:0,            lat:-1});
    dir.push_back('{rd:1, wr:0, m2r:1, rw:1, dest:12, alu:32'h54,   b:0,            rdata:32'h600DCAFE, lat:TO});
    foreach (dir[i]) run_instr(dir[i]);
    for (int n = 0; n < 150; n++) run_instr(rand_instr());
    drv_done = 1;
  endtask

  task automatic run_monitor();
    exp_t        e;
    logic        s_stall, s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    while (!drv_done || sb.size() != 0) begin
      @(negedge clk); #3;
      s_stall = stall; s_req = dmem_req; s_we = dmem_we;
      s_addr = dmem_addr; s_wdata = dmem_wdata;
      @(posedge clk); #1;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) continue;
      e = sb.pop_front();
      check("stall",      32'(s_stall),    32'(e.stall));
      check("dmem_req",   32'(s_req),      32'(e.req));
      check("dmem_we",    32'(s_we),       32'(e.we));
      check("dmem_addr",  s_addr,          e.addr);
      check("dmem_wdata", s_wdata,         e.wdata);
      check("o_RegWrite", 32'(o_RegWrite), 32'(e.rw));
      check("o_dest",     32'(o_dest),     32'(e.dest));
      check("o_wb_data",  o_wb_data,       e.data);
      check("o_misalign", 32'(o_misalign), 32'(e.mis));
      check("o_bus_err",  32'(o_bus_err),  32'(e.berr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_o_RegWrite", 32'(o_RegWrite), 32'd0);
    check("rst_o_dest",     32'(o_dest),     32'd0);
    check("rst_o_wb_data",  o_wb_data,       32'd0);
    check("rst_o_misalign", 32'(o_misalign), 32'd0);
    check("rst_o_bus_err",  32'(o_bus_err),  32'd0);
    check("rst_stall",      32'(stall),      32'd0);
    check("rst_dmem_req",   32'(dmem_req),   32'd0);
    rst_n = 1;

    fork
      run_driver();
      run_monitor();
    join

    // Reset while an access is stuck in WAIT.
    @(negedge clk);
    clear_inputs();
    i_MemRead = 1; i_MemtoReg = 1; i_RegWrite = 1; i_dest = 5'd9; i_alu_out = 32'h80;
    repeat (2) @(negedge clk);
    #1;
    check("midwait_stall_pre",   32'(stall),     32'd1);
    check("midwait_bus_err_pre", 32'(o_bus_err), 32'd1);
    #1 rst_n = 0;
    #1;
    check("midwait_req",        32'(dmem_req),   32'd0);
    check("midwait_stall",      32'(stall),      32'd0);
    check("midwait_o_RegWrite", 32'(o_RegWrite), 32'd0);
    check("midwait_o_dest",     32'(o_dest),     32'd0);
    check("midwait_o_wb_data",  o_wb_data,       32'd0);
    check("midwait_o_bus_err",  32'(o_bus_err),  32'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    @(negedge clk);
    i_RegWrite = 1; i_dest = 5'd3; i_alu_out = 32'hA5A5;
    #1;
    check("post_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("post_rst_o_RegWrite", 32'(o_RegWrite), 32'd1);
    check("post_rst_o_dest",     32'(o_dest),     32'd3);
    check("post_rst_o_wb_data",  o_wb_data,       32'hA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
